// File: rtl/alu_op_sequencer_if.sv
// Program-write and ALU drive bundle for alu_op_sequencer.
// master = sequencer side, slave = host/ALU side.
interface alu_op_sequencer_if #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned OPW   = 7,
  parameter int unsigned OPC   = 3
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned DW = OPC + OPW;

  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;
  logic          start;
  logic          clear;
  logic [OPC-1:0] alu_opcode;
  logic [OPW-1:0] alu_operand;
  logic [OPW-1:0] alu_result;
  logic          alu_carry;
  logic          busy;
  logic          done;
  logic [OPW-1:0] result;
  logic          carry;
  logic [CW-1:0] count;

  modport master (
    input  wr_valid, wr_data, start, clear, alu_result, alu_carry,
    output wr_ready, alu_opcode, alu_operand, busy, done, result, carry, count
  );

  modport slave (
    output wr_valid, wr_data, start, clear, alu_result, alu_carry,
    input  wr_ready, alu_opcode, alu_operand, busy, done, result, carry, count
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Buffers {opcode, operand} instructions and plays them into the accumulator
// ALU one per clock, then captures accumulator/carry and pulses done.
module alu_op_sequencer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned OPW   = 7,
  parameter int unsigned OPC   = 3
) (
  input logic                clk,
  input logic                rst,
  alu_op_sequencer_if.master bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned DW = OPC + OPW;
  localparam logic [OPC-1:0] NOP = '0;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  count_q, count_d;
  logic [CW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [OPC-1:0] opcode_q, opcode_d;
  logic [OPW-1:0] operand_q, operand_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [OPW-1:0] result_q, result_d;
  logic           carry_q, carry_d;

  logic [DW-1:0]  mem [DEPTH];
  logic [DW-1:0]  entry0;
  logic [DW-1:0]  head;
  logic           wr_ready_c;
  logic           wr_fire;

  assign wr_ready_c = (state_q == IDLE) && (count_q < CW'(DEPTH)) && !bus.clear;
  assign wr_fire    = bus.wr_valid && wr_ready_c;

  // Program storage; contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[count_q[AW-1:0]] <= bus.wr_data;
  end

  // Next state and next registered outputs.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    rd_ptr_d  = rd_ptr_q;
    opcode_d  = NOP;
    operand_d = '0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    result_d  = result_q;
    carry_d   = carry_q;
    entry0    = mem[AW'(0)];
    head      = mem[rd_ptr_q[AW-1:0]];

    if (wr_fire) count_d = count_q + CW'(1);

    case (state_q)
      IDLE: begin
        if (bus.clear) begin
          count_d = '0;
        end else if (bus.start) begin
          if (count_q != '0) begin
            state_d   = RUN;
            opcode_d  = entry0[DW-1 -: OPC];
            operand_d = entry0[OPW-1:0];
            rd_ptr_d  = CW'(1);
            busy_d    = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        // Past the last entry, drive NOP so the ALU holds while we drain.
        if (rd_ptr_q == count_q) begin
          state_d = DRAIN;
        end else begin
          opcode_d  = head[DW-1 -: OPC];
          operand_d = head[OPW-1:0];
          rd_ptr_d  = rd_ptr_q + CW'(1);
        end
      end
      DRAIN: begin
        result_d = bus.alu_result;
        carry_d  = bus.alu_carry;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      rd_ptr_q  <= '0;
      opcode_q  <= NOP;
      operand_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      carry_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rd_ptr_q  <= rd_ptr_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
      carry_q   <= carry_d;
    end
  end

  assign bus.wr_ready    = wr_ready_c;
  assign bus.alu_opcode  = opcode_q;
  assign bus.alu_operand = operand_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.result      = result_q;
  assign bus.carry       = carry_q;
  assign bus.count       = count_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural accumulator ALU.
module tb_alu_op_sequencer;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  alu_op_sequencer_if #(.DEPTH(8), .OPW(7), .OPC(3)) bus ();

  alu_op_sequencer #(.DEPTH(8), .OPW(7), .OPC(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Accumulator ALU environment model
  logic [6:0] alu_acc;
  logic       alu_c;
  logic [7:0] alu_sum;

  always_comb begin
    alu_sum = 8'd0;
    if (bus.alu_opcode == 3'd2) alu_sum = 8'(alu_acc) + 8'(bus.alu_operand);
    if (bus.alu_opcode == 3'd3) alu_sum = 8'(alu_acc) - 8'(bus.alu_operand);
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_acc <= 7'd0;
      alu_c   <= 1'b0;
    end else begin
      case (bus.alu_opcode)
        3'd1: begin alu_acc <= bus.alu_operand; alu_c <= 1'b0; end
        3'd2, 3'd3: begin alu_acc <= alu_sum[6:0]; alu_c <= alu_sum[7]; end
        default: ;
      endcase
    end
  end

  assign bus.alu_result = alu_acc;
  assign bus.alu_carry  = alu_c;

  int n_chk = 0;
  int n_err = 0;
  int busy_cycles = 0;
  int model_cnt = 0;
  logic [9:0] prog[$];
  logic [9:0] exp_ops[$];
  logic [7:0] exp_res[$];
  logic [6:0] ref_acc = 7'd0;
  logic       ref_c = 1'b0;
  logic [6:0] last_res = 7'd0;
  logic       last_c = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic ref_step(input logic [9:0] e);
    logic [7:0] s;
    case (e[9:7])
      3'd1: begin ref_acc = e[6:0]; ref_c = 1'b0; end
      3'd2: begin s = {1'b0, ref_acc} + {1'b0, e[6:0]}; ref_acc = s[6:0]; ref_c = s[7]; end
      3'd3: begin s = {1'b0, ref_acc} - {1'b0, e[6:0]}; ref_acc = s[6:0]; ref_c = s[7]; end
      default: ;
    endcase
  endtask

  // Output monitor: pops the expected drive per busy cycle and result per done.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.busy) begin
        busy_cycles++;
        if (exp_ops.size() == 0) check("unexpected_busy", 32'(bus.busy), 32'd0);
        else check("alu_drive", 32'({bus.alu_opcode, bus.alu_operand}), 32'(exp_ops.pop_front()));
      end else if (bus.alu_opcode != 3'd0) begin
        check("idle_nop", 32'(bus.alu_opcode), 32'd0);
      end
      if (bus.done) begin
        if (exp_res.size() == 0) begin
          check("spurious_done", 32'(bus.done), 32'd0);
        end else begin
          logic [7:0] e;
          e = exp_res.pop_front();
          check("result", 32'(bus.result), 32'(e[6:0]));
          check("carry", 32'(bus.carry), 32'(e[7]));
        end
      end
    end
  end

  task automatic write_word(input logic [2:0] opc, input logic [6:0] opr);
    @(negedge clk);
    bus.wr_valid = 1'b1;
    bus.wr_data  = {opc, opr};
    check("wr_ready", 32'(bus.wr_ready), 32'(model_cnt < 8));
    if (model_cnt < 8) begin
      prog.push_back({opc, opr});
      model_cnt++;
    end
    @(posedge clk);
  endtask

  task automatic end_writes();
    @(negedge clk);
    bus.wr_valid = 1'b0;
    check("count", 32'(bus.count), 32'(model_cnt));
  endtask

  task automatic clear_prog();
    @(negedge clk);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    prog.delete();
    model_cnt = 0;
    check("count_clear", 32'(bus.count), 32'd0);
  endtask

  task automatic run_prog(input bit clr_mid);
    int n;
    int lat;
    n = prog.size();
    @(negedge clk);
    if (n > 0) begin
      foreach (prog[i]) begin
        exp_ops.push_back(prog[i]);
        ref_step(prog[i]);
      end
      exp_ops.push_back(10'd0);
      last_res = ref_acc;
      last_c   = ref_c;
    end
    exp_res.push_back({last_c, last_res});
    busy_cycles = 0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.clear = clr_mid;
    lat = 0;
    while (!bus.done && lat < 40) begin
      @(negedge clk);
      bus.clear = 1'b0;
      lat++;
    end
    bus.clear = 1'b0;
    check("latency", 32'(lat), 32'((n == 0) ? 0 : n + 1));
    check("busy_cycles", 32'(busy_cycles), 32'((n == 0) ? 0 : n + 1));
    @(negedge clk);
    check("done_one_cycle", 32'(bus.done), 32'd0);
    check("count_kept", 32'(bus.count), 32'(model_cnt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.wr_valid = 1'b0;
    bus.wr_data  = 10'd0;
    bus.start    = 1'b0;
    bus.clear    = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_opcode", 32'(bus.alu_opcode), 32'd0);
    check("rst_operand", 32'(bus.alu_operand), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", 32'({bus.carry, bus.result}), 32'd0);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_wr_ready", 32'(bus.wr_ready), 32'd1);
    #2 rst = 1'b0;

    // LOAD 5, ADD 3
    write_word(3'd1, 7'd5);
    write_word(3'd2, 7'd3);
    end_writes();
    run_prog(1'b0);

    // Overflow into carry, then replay the same program
    clear_prog();
    write_word(3'd1, 7'd127);
    write_word(3'd2, 7'd1);
    end_writes();
    run_prog(1'b0);
    run_prog(1'b0);

    // Start with an empty buffer: done only, result retained
    clear_prog();
    run_prog(1'b0);

    // clear wins over start
    write_word(3'd1, 7'd1);
    write_word(3'd2, 7'd2);
    write_word(3'd3, 7'd3);
    end_writes();
    @(negedge clk);
    bus.clear = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    bus.start = 1'b0;
    prog.delete();
    model_cnt = 0;
    busy_cycles = 0;
    repeat (3) @(negedge clk);
    check("clr_start_count", 32'(bus.count), 32'd0);
    check("clr_start_busy", 32'(busy_cycles), 32'd0);

    // clear during RUN is ignored; unassigned opcode passes through
    write_word(3'd1, 7'd20);
    write_word(3'd3, 7'd7);
    write_word(3'd6, 7'd99);
    end_writes();
    run_prog(1'b1);

    // Nine writes with valid held: only eight stored
    clear_prog();
    for (int i = 0; i < 9; i++)
      write_word((i % 4 == 0) ? 3'd1 : (i % 4 == 1) ? 3'd2 : (i % 4 == 2) ? 3'd3 : 3'd7, 7'(40 + i));
    end_writes();
    check("full_wr_ready", 32'(bus.wr_ready), 32'd0);
    run_prog(1'b0);

    // Reset in the second cycle of a four-entry run
    clear_prog();
    for (int i = 0; i < 4; i++) write_word(3'd2, 7'(i + 1));
    end_writes();
    @(negedge clk);
    exp_ops.push_back(prog[0]);
    exp_ops.push_back(prog[1]);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_opcode", 32'(bus.alu_opcode), 32'd0);
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    check("rst_mid_count", 32'(bus.count), 32'd0);
    check("rst_mid_result", 32'({bus.carry, bus.result}), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    prog.delete();
    model_cnt = 0;
    ref_acc = 7'd0;
    ref_c = 1'b0;
    last_res = 7'd0;
    last_c = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_done", 32'(bus.done), 32'd0);
    check("post_rst_busy", 32'(bus.busy), 32'd0);

    // Fresh program after reset
    write_word(3'd1, 7'd9);
    write_word(3'd2, 7'd2);
    end_writes();
    run_prog(1'b0);

    repeat (2) @(negedge clk);
    check("ops_drained", 32'(exp_ops.size()), 32'd0);
    check("results_drained", 32'(exp_res.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Program-driven initiator for the accumulator ALU: buffers a short list of {opcode, operand} instructions written over a valid/ready port, then on `start` issues them to the ALU one per clock. After the ALU has registered the last instruction, the sequencer captures the accumulator and carry and pulses `done`. It sits between host/test logic and the ALU's opcode/operand inputs, and is the driving end of that interface.

## Interface
- `DEPTH`, 8: program buffer entries (power of two, 2..16)
- `OPW`, 7: operand and accumulator width
- `OPC`, 3: opcode width
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `wr_valid` in 1: program write request
- `wr_ready` out 1: buffer can accept a write this cycle
- `wr_data` in OPC+OPW: {opcode, operand}; opcode in the MSBs
- `start` in 1: begin playback (level sampled each edge)
- `clear` in 1: empty the program buffer
- `alu_opcode` out OPC: registered opcode to the ALU
- `alu_operand` out OPW: registered operand to the ALU
- `alu_result` in OPW: ALU accumulator
- `alu_carry` in 1: ALU carry flag
- `busy` out 1: playback in progress
- `done` out 1: one-cycle pulse, result captured
- `result` out OPW: captured accumulator
- `carry` out 1: captured carry
- `count` out log2(DEPTH)+1: number of stored entries

## Operation
- States: IDLE, RUN, DRAIN.
- Reset values: state IDLE; `count`=0; `alu_opcode`=000 (NOP); `alu_operand`=0; `busy`=0; `done`=0; `result`=0; `carry`=0; write pointer and read pointer = 0. Buffer contents are not reset.
- Writes happen only in IDLE. `wr_ready` = (state==IDLE) && (`count`<DEPTH) && !`clear`. On `wr_valid`&&`wr_ready`, store `wr_data` at index `count` and increment `count`. When the buffer is full (`count`==DEPTH), `wr_ready`=0 and no overwrite occurs.
- Opcode bits pass through unchanged, including unassigned encodings. The ALU encodings are NOP=000, LOAD=001, ADD=010, SUB=011.
- `clear` in IDLE sets `count` to 0 next edge. If `clear` and `start` are both high, `clear` wins and no run starts. `clear` is ignored when not in IDLE.
- In IDLE with `start`=1 and `count`=N>0: move to RUN, load `alu_opcode`/`alu_operand` from entry 0, read pointer := 1, `busy`:=1.
- RUN: each edge loads the entry at the read pointer and increments the pointer. The edge that would load index N instead loads NOP/0 and moves to DRAIN.
- DRAIN: on the next edge, `result`:=`alu_result`, `carry`:=`alu_carry`, `done`:=1, `busy`:=0, state IDLE.
- `start` in IDLE with `count`=0: no RUN, `done` pulses the next cycle, and `result`/`carry` are unchanged.
- `start` and `wr_valid` are ignored while `busy`. The program is retained after a run and can be replayed by asserting `start` again.
- Outside RUN, `alu_opcode`=NOP, so the ALU accumulator holds.

## Timing
- Let E0 be the edge that samples `start` with `count`=N.
- Entry k is driven in the cycle after edge Ek, and the ALU registers it at edge E(k+1).
- The last entry is registered by the ALU at EN. The sequencer enters DRAIN at EN and captures the result at E(N+1).
- `done` is high for exactly the cycle after E(N+1). `busy` is high from after E0 until E(N+1).
- Total latency from `start` to `done` is N+1 cycles.
- A new `start` is accepted at the edge where `done` is high, giving back-to-back runs.
- `rst` mid-run immediately forces all reset values. `alu_opcode` drops to NOP asynchronously and no `done` pulse is produced.
- A write at the edge where `count` reaches DEPTH is accepted. The next cycle shows `wr_ready`=0.

## Test plan
- Write {001,5} and {010,3}, then pulse `start` (ALU model reset, carry 0) -> `alu_opcode` sequence 001, 010, 000. `done` is high 3 cycles after E0. `result`=8, `carry`=0, `busy` is high for 3 cycles.
- Write {001,127} and {010,1}, then start -> `result`=0, `carry`=1. Replay with `start` again and no writes -> identical opcode sequence and `done` after 3 cycles.
- Write 9 entries with `wr_valid` held high -> exactly 8 accepted, `count`=8, `wr_ready`=0 after the 8th. The 9th value never appears on `alu_operand`.
- `start` with `count`=0 -> `busy` stays 0, `done` pulses the next cycle, and `result`/`carry` keep their prior values.
- `clear` and `start` high together in IDLE with `count`=3 -> `count`=0, no RUN, no `done`. `clear` asserted during RUN -> ignored, run completes normally.
- Assert `rst` in the 2nd cycle of a 4-entry run -> all outputs take their reset values at once, `count`=0, no `done`. A fresh write and `start` after reset runs normally.
